acsu_param: RTL and testbench

//  Parametrised add-compare-select unit for a rate-1/n shift-register trellis with NS=2^M states.

---
 rtl/acsu_param.sv | 146 ++++++++++++++
 tb/tb_acsu_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acsu_param.sv
// acsu_param: add-compare-select over a 2^M-state shift-register trellis with MSB-based
// metric normalisation and saturating adds. ACSU_BEST_STATE_EN adds best_state/best_pm outputs.
module acsu_param #(
  parameter int M    = 3,
  parameter int W    = 8,
  parameter int BMW  = 3,
  parameter int CNTW = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    init,
  input  logic                    bm_valid,
  input  logic [(2**M)*2*BMW-1:0] bm_in,
  output logic                    dec_valid,
  output logic [(2**M)-1:0]       dec_out,
  output logic [(2**M)*W-1:0]     pm_out,
  output logic                    norm_pulse,
  output logic [CNTW-1:0]         stage_cnt
`ifdef ACSU_BEST_STATE_EN
  ,
  output logic [M-1:0]            best_state,
  output logic [W-1:0]            best_pm
`endif
);

  localparam int NS = 2**M;
  localparam logic [W-1:0] PM_SEED = W'(2**(W-2));

  logic [NS-1:0][W-1:0] pm_q, pm_d, pm_norm, pm_acs, pm_init;
  logic [NS-1:0]        dec_q, dec_d, dec_acs;
  logic                 dec_valid_q, dec_valid_d;
  logic                 norm_pulse_q, norm_pulse_d;
  logic                 all_msb;
  logic [CNTW-1:0]      stage_cnt_q, stage_cnt_d;

  // Normalise only when every metric has its MSB set, so relative order is preserved.
  always_comb begin
    all_msb = 1'b1;
    for (int s = 0; s < NS; s++) begin
      all_msb    = all_msb & pm_q[s][W-1];
      pm_init[s] = (s == 0) ? '0 : PM_SEED;
    end
    for (int s = 0; s < NS; s++) begin
      pm_norm[s] = all_msb ? {1'b0, pm_q[s][W-2:0]} : pm_q[s];
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam int PA = (2*s) % NS;
    localparam int PB = (2*s + 1) % NS;
    logic [W:0]   ca_sum, cb_sum;
    logic [W-1:0] ca, cb;
    logic         sel_b;
    assign ca_sum     = {1'b0, pm_norm[PA]} + {{(W+1-BMW){1'b0}}, bm_in[(2*s)*BMW +: BMW]};
    assign cb_sum     = {1'b0, pm_norm[PB]} + {{(W+1-BMW){1'b0}}, bm_in[(2*s+1)*BMW +: BMW]};
    assign ca         = ca_sum[W] ? {W{1'b1}} : ca_sum[W-1:0];
    assign cb         = cb_sum[W] ? {W{1'b1}} : cb_sum[W-1:0];
    assign sel_b      = (cb < ca);
    assign dec_acs[s] = sel_b;
    assign pm_acs[s]  = sel_b ? cb : ca;
  end

  always_comb begin
    pm_d         = pm_q;
    dec_d        = dec_q;
    dec_valid_d  = 1'b0;
    norm_pulse_d = 1'b0;
    stage_cnt_d  = stage_cnt_q;
    if (init) begin
      pm_d        = pm_init;
      dec_d       = '0;
      stage_cnt_d = '0;
    end else if (bm_valid) begin
      pm_d         = pm_acs;
      dec_d        = dec_acs;
      dec_valid_d  = 1'b1;
      norm_pulse_d = all_msb;
      stage_cnt_d  = stage_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pm_q         <= pm_init;
      dec_q        <= '0;
      dec_valid_q  <= 1'b0;
      norm_pulse_q <= 1'b0;
      stage_cnt_q  <= '0;
    end else begin
      pm_q         <= pm_d;
      dec_q        <= dec_d;
      dec_valid_q  <= dec_valid_d;
      norm_pulse_q <= norm_pulse_d;
      stage_cnt_q  <= stage_cnt_d;
    end
  end

  assign pm_out     = pm_q;
  assign dec_out    = dec_q;
  assign dec_valid  = dec_valid_q;
  assign norm_pulse = norm_pulse_q;
  assign stage_cnt  = stage_cnt_q;

`ifdef ACSU_BEST_STATE_EN
  logic [M-1:0] best_state_q, best_state_d, best_idx;
  logic [W-1:0] best_pm_q, best_pm_d, best_val;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = pm_acs[0];
    for (int s = 1; s < NS; s++) begin
      if (pm_acs[s] < best_val) begin
        best_val = pm_acs[s];
        best_idx = M'(s);
      end
    end
  end

  always_comb begin
    best_state_d = best_state_q;
    best_pm_d    = best_pm_q;
    if (init) begin
      best_state_d = '0;
      best_pm_d    = '0;
    end else if (bm_valid) begin
      best_state_d = best_idx;
      best_pm_d    = best_val;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      best_state_q <= '0;
      best_pm_q    <= '0;
    end else begin
      best_state_q <= best_state_d;
      best_pm_q    <= best_pm_d;
    end
  end

  assign best_state = best_state_q;
  assign best_pm    = best_pm_q;
`endif

endmodule

// File: tb/tb_acsu_param.sv
// Directed bench for acsu_param: a default 8-state instance plus a deliberately narrow
// 2-state instance (W=3, CNTW=2) that makes saturation and counter wrap reachable.
module tb_acsu_param;
  localparam int M = 3, W = 8, BMW = 3, CNTW = 16, NS = 8;

  logic                 clock = 1'b0;
  logic                 reset, init, bm_valid;
  logic [NS*2*BMW-1:0]  bm_in;
  logic                 dec_valid, norm_pulse;
  logic [NS-1:0]        dec_out;
  logic [NS*W-1:0]      pm_out;
  logic [CNTW-1:0]      stage_cnt;

  logic                 init_s, bm_valid_s;
  logic [11:0]          bm_in_s;
  logic                 dec_valid_s, norm_pulse_s;
  logic [1:0]           dec_out_s;
  logic [5:0]           pm_out_s;
  logic [1:0]           stage_cnt_s;

`ifdef ACSU_BEST_STATE_EN
  logic [M-1:0] best_state;
  logic [W-1:0] best_pm;
  logic [0:0]   best_state_s;
  logic [2:0]   best_pm_s;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  acsu_param #(.M(M), .W(W), .BMW(BMW), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .init(init), .bm_valid(bm_valid), .bm_in(bm_in),
    .dec_valid(dec_valid), .dec_out(dec_out), .pm_out(pm_out), .norm_pulse(norm_pulse),
    .stage_cnt(stage_cnt)
`ifdef ACSU_BEST_STATE_EN
    , .best_state(best_state), .best_pm(best_pm)
`endif
  );

  acsu_param #(.M(1), .W(3), .BMW(3), .CNTW(2)) dut_s (
    .clock(clock), .reset(reset), .init(init_s), .bm_valid(bm_valid_s), .bm_in(bm_in_s),
    .dec_valid(dec_valid_s), .dec_out(dec_out_s), .pm_out(pm_out_s), .norm_pulse(norm_pulse_s),
    .stage_cnt(stage_cnt_s)
`ifdef ACSU_BEST_STATE_EN
    , .best_state(best_state_s), .best_pm(best_pm_s)
`endif
  );

  function automatic logic [63:0] pm8(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7);
    return {p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_bm(input int s, input logic [2:0] a, input logic [2:0] b);
    bm_in[(2*s)*BMW +: BMW]   = a;
    bm_in[(2*s+1)*BMW +: BMW] = b;
  endtask

  task automatic fill_bm(input logic [2:0] v);
    for (int s = 0; s < NS; s++) set_bm(s, v, v);
  endtask

  task automatic apply_reset();
    reset = 1'b1; init = 1'b0; bm_valid = 1'b0; init_s = 1'b0; bm_valid_s = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (pm_out !== pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64)) begin
      n_fail++; $display("FAIL reset_pm: got %h expected %h", pm_out, pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64)); end
    n_tests++; if (dec_valid !== 1'b0 || dec_out !== 8'h00 || norm_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got dv=%b dec=%h np=%b expected 0 00 0", dec_valid, dec_out, norm_pulse); end
    n_tests++; if (stage_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stage_cnt); end
`ifdef ACSU_BEST_STATE_EN
    n_tests++; if (best_state !== 3'd0 || best_pm !== 8'd0) begin
      n_fail++; $display("FAIL reset_best: got %0d/%0d expected 0/0", best_state, best_pm); end
`endif
  endtask

  task automatic test_all_zero();
    apply_reset();
    fill_bm(3'd0);
    bm_valid = 1'b1;
    tick();
    bm_valid = 1'b0;
    n_tests++; if (dec_valid !== 1'b1) begin
      n_fail++; $display("FAIL zero_dv: got %b expected 1", dec_valid); end
    n_tests++; if (pm_out !== pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64)) begin
      n_fail++; $display("FAIL zero_pm: got %h expected %h", pm_out, pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64)); end
    n_tests++; if (dec_out !== 8'h00 || norm_pulse !== 1'b0 || stage_cnt !== 16'd1) begin
      n_fail++; $display("FAIL zero_dec: got dec=%h np=%b cnt=%0d expected 00 0 1", dec_out, norm_pulse, stage_cnt); end
`ifdef ACSU_BEST_STATE_EN
    n_tests++; if (best_state !== 3'd0 || best_pm !== 8'd0) begin
      n_fail++; $display("FAIL zero_best: got %0d/%0d expected 0/0", best_state, best_pm); end
`endif
    tick();
    n_tests++; if (dec_valid !== 1'b0 || stage_cnt !== 16'd1) begin
      n_fail++; $display("FAIL zero_idle: got dv=%b cnt=%0d expected 0 1", dec_valid, stage_cnt); end
    n_tests++; if (pm_out !== pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64)) begin
      n_fail++; $display("FAIL zero_hold: got %h expected %h", pm_out, pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64)); end
  endtask

  task automatic test_select_tie();
    apply_reset();
    fill_bm(3'd0);
    set_bm(0, 3'd7, 3'd0);
    set_bm(1, 3'd5, 3'd2);
    set_bm(2, 3'd3, 3'd3);
    bm_valid = 1'b1;
    tick();
    n_tests++; if (pm_out !== pm8(8'd7, 8'd66, 8'd67, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64)) begin
      n_fail++; $display("FAIL sel_pm1: got %h expected %h", pm_out, pm8(8'd7, 8'd66, 8'd67, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64)); end
    n_tests++; if (dec_out !== 8'h02) begin
      n_fail++; $display("FAIL sel_dec1: got %h expected 02", dec_out); end
`ifdef ACSU_BEST_STATE_EN
    n_tests++; if (best_state !== 3'd4 || best_pm !== 8'd0) begin
      n_fail++; $display("FAIL sel_best1: got %0d/%0d expected 4/0", best_state, best_pm); end
`endif
    fill_bm(3'd0);
    tick();
    bm_valid = 1'b0;
    n_tests++; if (pm_out !== pm8(8'd7, 8'd64, 8'd0, 8'd64, 8'd7, 8'd64, 8'd0, 8'd64)) begin
      n_fail++; $display("FAIL sel_pm2: got %h expected %h", pm_out, pm8(8'd7, 8'd64, 8'd0, 8'd64, 8'd7, 8'd64, 8'd0, 8'd64)); end
    n_tests++; if (dec_out !== 8'h22 || dec_valid !== 1'b1 || stage_cnt !== 16'd2) begin
      n_fail++; $display("FAIL sel_dec2: got dec=%h dv=%b cnt=%0d expected 22 1 2", dec_out, dec_valid, stage_cnt); end
`ifdef ACSU_BEST_STATE_EN
    n_tests++; if (best_state !== 3'd2 || best_pm !== 8'd0) begin
      n_fail++; $display("FAIL sel_best2: got %0d/%0d expected 2/0", best_state, best_pm); end
`endif
  endtask

  task automatic test_normalise();
    int norm_seen;
    norm_seen = 0;
    apply_reset();
    fill_bm(3'd7);
    bm_valid = 1'b1;
    repeat (19) begin
      tick();
      if (norm_pulse === 1'b1) norm_seen++;
    end
    n_tests++; if (norm_seen != 0) begin
      n_fail++; $display("FAIL norm_early: got %0d pulses expected 0", norm_seen); end
    n_tests++; if (pm_out !== {8{8'd133}} || stage_cnt !== 16'd19) begin
      n_fail++; $display("FAIL norm_pm19: got %h cnt=%0d expected all 85 cnt=19", pm_out, stage_cnt); end
    tick();
    bm_valid = 1'b0;
    n_tests++; if (norm_pulse !== 1'b1 || dec_valid !== 1'b1) begin
      n_fail++; $display("FAIL norm_pulse: got np=%b dv=%b expected 1 1", norm_pulse, dec_valid); end
    n_tests++; if (pm_out !== {8{8'd12}} || dec_out !== 8'h00 || stage_cnt !== 16'd20) begin
      n_fail++; $display("FAIL norm_pm20: got %h dec=%h cnt=%0d expected all 0c dec 00 cnt=20", pm_out, dec_out, stage_cnt); end
`ifdef ACSU_BEST_STATE_EN
    n_tests++; if (best_state !== 3'd0 || best_pm !== 8'd12) begin
      n_fail++; $display("FAIL norm_best: got %0d/%0d expected 0/12", best_state, best_pm); end
`endif
    tick();
    n_tests++; if (norm_pulse !== 1'b0 || dec_valid !== 1'b0 || pm_out !== {8{8'd12}}) begin
      n_fail++; $display("FAIL norm_after: got np=%b dv=%b pm=%h expected 0 0 all 0c", norm_pulse, dec_valid, pm_out); end
  endtask

  task automatic test_init();
    apply_reset();
    fill_bm(3'd0);
    set_bm(0, 3'd7, 3'd0);
    set_bm(1, 3'd5, 3'd2);
    bm_valid = 1'b1;
    tick();
    fill_bm(3'd7);
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    bm_valid = 1'b0;
    n_tests++; if (dec_valid !== 1'b0 || dec_out !== 8'h00 || stage_cnt !== 16'd0) begin
      n_fail++; $display("FAIL init_flags: got dv=%b dec=%h cnt=%0d expected 0 00 0", dec_valid, dec_out, stage_cnt); end
    n_tests++; if (pm_out !== pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64)) begin
      n_fail++; $display("FAIL init_pm: got %h expected %h", pm_out, pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64)); end
`ifdef ACSU_BEST_STATE_EN
    n_tests++; if (best_state !== 3'd0 || best_pm !== 8'd0) begin
      n_fail++; $display("FAIL init_best: got %0d/%0d expected 0/0", best_state, best_pm); end
`endif
    fill_bm(3'd0);
    bm_valid = 1'b1;
    tick();
    bm_valid = 1'b0;
    n_tests++; if (pm_out !== pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64) || stage_cnt !== 16'd1) begin
      n_fail++; $display("FAIL init_restart: got %h cnt=%0d expected %h cnt=1", pm_out, stage_cnt, pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd0, 8'd64, 8'd64, 8'd64)); end
  endtask

  task automatic test_reset_priority();
    apply_reset();
    fill_bm(3'd7);
    bm_valid = 1'b1;
    tick();
    reset = 1'b1;
    init = 1'b1;
    tick();
    reset = 1'b0;
    init = 1'b0;
    bm_valid = 1'b0;
    n_tests++; if (dec_valid !== 1'b0 || stage_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_flags: got dv=%b cnt=%0d expected 0 0", dec_valid, stage_cnt); end
    n_tests++; if (pm_out !== pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64)) begin
      n_fail++; $display("FAIL rst_mid_pm: got %h expected %h", pm_out, pm8(8'd0, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64)); end
  endtask

  task automatic test_saturation();
    apply_reset();
    n_tests++; if (pm_out_s !== 6'b010_000) begin
      n_fail++; $display("FAIL sat_reset: got %b expected 010000", pm_out_s); end
    bm_in_s = 12'hFFF;
    bm_valid_s = 1'b1;
    tick();
    n_tests++; if (pm_out_s !== 6'b111_111 || dec_out_s !== 2'b00 || norm_pulse_s !== 1'b0) begin
      n_fail++; $display("FAIL sat_clamp: got pm=%b dec=%b np=%b expected 111111 00 0", pm_out_s, dec_out_s, norm_pulse_s); end
    bm_in_s = {3'd7, 3'd7, 3'd1, 3'd7};
    tick();
    bm_valid_s = 1'b0;
    n_tests++; if (pm_out_s !== 6'b111_100 || dec_out_s !== 2'b01) begin
      n_fail++; $display("FAIL sat_norm_pm: got pm=%b dec=%b expected 111100 01", pm_out_s, dec_out_s); end
    n_tests++; if (norm_pulse_s !== 1'b1 || dec_valid_s !== 1'b1 || stage_cnt_s !== 2'd2) begin
      n_fail++; $display("FAIL sat_norm_flags: got np=%b dv=%b cnt=%0d expected 1 1 2", norm_pulse_s, dec_valid_s, stage_cnt_s); end
`ifdef ACSU_BEST_STATE_EN
    n_tests++; if (best_state_s !== 1'b0 || best_pm_s !== 3'd4) begin
      n_fail++; $display("FAIL sat_best: got %0d/%0d expected 0/4", best_state_s, best_pm_s); end
`endif
  endtask

  task automatic test_counter_wrap();
    bm_in_s = 12'h000;
    bm_valid_s = 1'b1;
    tick();
    n_tests++; if (stage_cnt_s !== 2'd3 || dec_valid_s !== 1'b1) begin
      n_fail++; $display("FAIL wrap_cnt3: got cnt=%0d dv=%b expected 3 1", stage_cnt_s, dec_valid_s); end
    tick();
    bm_valid_s = 1'b0;
    n_tests++; if (stage_cnt_s !== 2'd0 || dec_valid_s !== 1'b1) begin
      n_fail++; $display("FAIL wrap_cnt0: got cnt=%0d dv=%b expected 0 1", stage_cnt_s, dec_valid_s); end
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; bm_valid = 1'b0;
    init_s = 1'b0; bm_valid_s = 1'b0; bm_in_s = '0;
    fill_bm(3'd0);
    test_reset();
    test_all_zero();
    test_select_tie();
    test_normalise();
    test_init();
    test_reset_priority();
    test_saturation();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
